axi_slave_mem: RTL and testbench

//  AXI3-style memory-mapped slave with an internal byte-addressable RAM. Serves one write burst and one read burst at a time.
//  The write path and the read path run concurrently and independently. Sits behind the tbbfm bus interface as the device under test.

---
 rtl/axi_slave_mem_if.sv | 52 +++++
 rtl/axi_slave_mem.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_mem_if.sv
// AXI3-style bus bundle between a master and the axi_slave_mem slave.
interface axi_slave_mem_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SIZE  = 3
);
   localparam int unsigned IdW = WIDTH / 8;
   localparam int unsigned BW  = SIZE - 1;

   logic             AWVALID, AWREADY;
   logic [IdW-1:0]   AWID;
   logic [WIDTH-1:0] AWADDR;
   logic [IdW-1:0]   AWLEN;
   logic [SIZE-1:0]  AWSIZE;
   logic [BW-1:0]    AWBURST;

   logic             WVALID, WREADY, WLAST;
   logic [IdW-1:0]   WID;
   logic [IdW-1:0]   WSTRB;
   logic [WIDTH:0]   WDATA;

   logic             BVALID, BREADY;
   logic [IdW-1:0]   BID;
   logic [BW-1:0]    BRESP;

   logic             ARVALID, ARREADY;
   logic [IdW-1:0]   ARID;
   logic [WIDTH-1:0] ARADDR;
   logic [IdW-1:0]   ARLEN;
   logic [SIZE-1:0]  ARSIZE;
   logic [BW-1:0]    ARBURST;

   logic             RVALID, RREADY, RLAST;
   logic [IdW-1:0]   RID;
   logic [WIDTH-1:0] RDATA;
   logic [BW-1:0]    RRESP;

   modport master (
      output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, input AWREADY,
      output WVALID, WLAST, WID, WSTRB, WDATA, input WREADY,
      output BREADY, input BVALID, BID, BRESP,
      output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, input ARREADY,
      output RREADY, input RVALID, RID, RDATA, RRESP, RLAST
   );

   modport slave (
      input AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, output AWREADY,
      input WVALID, WLAST, WID, WSTRB, WDATA, output WREADY,
      input BREADY, output BVALID, BID, BRESP,
      input ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, output ARREADY,
      input RREADY, output RVALID, RID, RDATA, RRESP, RLAST
   );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI3-style slave with internal byte-addressable RAM; independent write and read FSMs,
// one outstanding burst per direction, FIXED/INCR/WRAP bursts, byte strobes.
module axi_slave_mem #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SIZE      = 3,
   parameter int unsigned MEM_BYTES = 1024
) (
   input logic            clk,
   input logic            reset,
   axi_slave_mem_if.slave bus
);
   localparam int unsigned IdW      = WIDTH / 8;
   localparam int unsigned BW       = SIZE - 1;
   localparam int unsigned AddrBits = $clog2(MEM_BYTES);
   localparam int unsigned Words    = MEM_BYTES / 4;
   localparam logic [BW-1:0] BurstFixed = BW'(0);
   localparam logic [BW-1:0] BurstIncr  = BW'(1);
   localparam logic [BW-1:0] BurstWrap  = BW'(2);
   localparam logic [BW-1:0] RespOkay   = BW'(0);
   localparam logic [BW-1:0] RespSlvErr = BW'(2);

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic [0:0] {RIdle, RData} r_state_e;

   // WRAP needs LEN+1 to be a power of two (2, 4, 8, 16 beats)
   function automatic logic wrap_len_ok(input logic [IdW-1:0] len);
      return (len != '0) && ((len & (len + IdW'(1))) == '0);
   endfunction

   function automatic logic cfg_bad(input logic [IdW-1:0] len, input logic [SIZE-1:0] size,
                                    input logic [BW-1:0] burst);
      return (size > SIZE'(2)) || (burst == '1) || ((burst == BurstWrap) && !wrap_len_ok(len));
   endfunction

   function automatic logic [WIDTH-1:0] next_addr(input logic [WIDTH-1:0] addr,
                                                  input logic [IdW-1:0]   len,
                                                  input logic [SIZE-1:0]  size,
                                                  input logic [BW-1:0]    burst);
      logic [WIDTH-1:0] bytes, incr, span, nxt;
      bytes = WIDTH'(1) << size;
      incr  = (addr & ~(bytes - WIDTH'(1))) + bytes;
      // LEN+1 is a power of two for legal WRAP, so span = bytes << popcount(LEN)
      span  = bytes << $countones(len);
      case (burst)
         BurstFixed: nxt = addr;
         BurstIncr:  nxt = incr;
         BurstWrap:  nxt = wrap_len_ok(len) ?
                           (addr & ~(span - WIDTH'(1))) + (incr & (span - WIDTH'(1))) : incr;
         default:    nxt = incr;
      endcase
      return nxt;
   endfunction

   logic [WIDTH-1:0] mem_q [Words];

   w_state_e         w_state_q, w_state_d;
   logic [IdW-1:0]   aw_id_q, aw_id_d, aw_len_q, aw_len_d, w_beat_q, w_beat_d;
   logic [WIDTH-1:0] w_addr_q, w_addr_d;
   logic [SIZE-1:0]  aw_size_q, aw_size_d;
   logic [BW-1:0]    aw_burst_q, aw_burst_d, bresp_q, bresp_d;
   logic             w_err_q, w_err_d, awready_q, awready_d, wready_q, wready_d;
   logic             bvalid_q, bvalid_d;
   logic [IdW-1:0]   bid_q, bid_d;
   logic             w_oob;
   logic [IdW-1:0]   mem_we;
   logic [AddrBits-3:0] mem_idx;

   r_state_e         r_state_q, r_state_d;
   logic [IdW-1:0]   ar_id_q, ar_id_d, ar_len_q, ar_len_d, r_beat_q, r_beat_d;
   logic [WIDTH-1:0] r_addr_q, r_addr_d, rd_addr;
   logic [SIZE-1:0]  ar_size_q, ar_size_d;
   logic [BW-1:0]    ar_burst_q, ar_burst_d, rresp_q, rresp_d;
   logic             arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic             rd_load, rd_last, rd_bad;
   logic [IdW-1:0]   rid_q, rid_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;

   logic unused_wdata_msb;
   assign unused_wdata_msb = bus.WDATA[WIDTH];

   // Write FSM next state, per-beat error accumulation and RAM write request
   always_comb begin
      w_state_d  = w_state_q;
      aw_id_d    = aw_id_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      aw_burst_d = aw_burst_q;
      w_addr_d   = w_addr_q;
      w_beat_d   = w_beat_q;
      w_err_d    = w_err_q;
      w_oob      = w_addr_q >= WIDTH'(MEM_BYTES);
      mem_we     = '0;
      mem_idx    = w_addr_q[AddrBits-1:2];
      unique case (w_state_q)
         WIdle: if (bus.AWVALID && awready_q) begin
            aw_id_d    = bus.AWID;
            aw_len_d   = bus.AWLEN;
            aw_size_d  = bus.AWSIZE;
            aw_burst_d = bus.AWBURST;
            w_addr_d   = bus.AWADDR;
            w_beat_d   = '0;
            w_err_d    = cfg_bad(bus.AWLEN, bus.AWSIZE, bus.AWBURST);
            w_state_d  = WData;
         end
         WData: if (bus.WVALID && wready_q) begin
            if (!w_oob) mem_we = bus.WSTRB;
            w_err_d  = w_err_q | w_oob | (bus.WLAST != (w_beat_q == aw_len_q)) |
                       (bus.WID != aw_id_q);
            w_addr_d = next_addr(w_addr_q, aw_len_q, aw_size_q, aw_burst_q);
            w_beat_d = w_beat_q + IdW'(1);
            if (w_beat_q == aw_len_q) w_state_d = WResp;
         end
         WResp: if (bus.BREADY && bvalid_q) w_state_d = WIdle;
         default: w_state_d = WIdle;
      endcase
      awready_d = (w_state_d == WIdle);
      wready_d  = (w_state_d == WData);
      bvalid_d  = (w_state_d == WResp);
      bid_d     = bvalid_d ? aw_id_d : '0;
      bresp_d   = (bvalid_d && w_err_d) ? RespSlvErr : RespOkay;
   end

   // Write FSM state and registered write-side outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_state_q  <= WIdle;
         aw_id_q    <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         aw_burst_q <= '0;
         w_addr_q   <= '0;
         w_beat_q   <= '0;
         w_err_q    <= 1'b0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bid_q      <= '0;
         bresp_q    <= '0;
      end else begin
         w_state_q  <= w_state_d;
         aw_id_q    <= aw_id_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         aw_burst_q <= aw_burst_d;
         w_addr_q   <= w_addr_d;
         w_beat_q   <= w_beat_d;
         w_err_q    <= w_err_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bid_q      <= bid_d;
         bresp_q    <= bresp_d;
      end
   end

   // RAM byte-lane writes; contents survive reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(IdW); i++) begin
         if (mem_we[i]) mem_q[mem_idx][8*i +: 8] <= bus.WDATA[8*i +: 8];
      end
   end

   // Read FSM next state; loads the next beat's data when a beat is due
   always_comb begin
      r_state_d  = r_state_q;
      ar_id_d    = ar_id_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      ar_burst_d = ar_burst_q;
      r_addr_d   = r_addr_q;
      r_beat_d   = r_beat_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rlast_d    = rlast_q;
      rid_d      = rid_q;
      rd_load    = 1'b0;
      rd_last    = 1'b0;
      rd_addr    = r_addr_q;
      unique case (r_state_q)
         RIdle: if (bus.ARVALID && arready_q) begin
            ar_id_d    = bus.ARID;
            ar_len_d   = bus.ARLEN;
            ar_size_d  = bus.ARSIZE;
            ar_burst_d = bus.ARBURST;
            rd_addr    = bus.ARADDR;
            rd_load    = 1'b1;
            rd_last    = (bus.ARLEN == '0);
            r_addr_d   = next_addr(bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST);
            r_beat_d   = IdW'(1);
            rid_d      = bus.ARID;
            r_state_d  = RData;
         end
         RData: if (bus.RREADY && rvalid_q) begin
            if (rlast_q) begin
               r_state_d = RIdle;
               rvalid_d  = 1'b0;
               rdata_d   = '0;
               rresp_d   = RespOkay;
               rlast_d   = 1'b0;
               rid_d     = '0;
            end else begin
               rd_load  = 1'b1;
               rd_last  = (r_beat_q == ar_len_q);
               r_addr_d = next_addr(r_addr_q, ar_len_q, ar_size_q, ar_burst_q);
               r_beat_d = r_beat_q + IdW'(1);
            end
         end
      endcase
      rd_bad = cfg_bad(ar_len_d, ar_size_d, ar_burst_d) || (rd_addr >= WIDTH'(MEM_BYTES));
      if (rd_load) begin
         rvalid_d = 1'b1;
         rlast_d  = rd_last;
         rdata_d  = rd_bad ? '0 : mem_q[rd_addr[AddrBits-1:2]];
         rresp_d  = rd_bad ? RespSlvErr : RespOkay;
      end
      arready_d = (r_state_d == RIdle);
   end

   // Read FSM state and registered read-side outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state_q  <= RIdle;
         ar_id_q    <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
         r_addr_q   <= '0;
         r_beat_q   <= '0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         rlast_q    <= 1'b0;
         rid_q      <= '0;
      end else begin
         r_state_q  <= r_state_d;
         ar_id_q    <= ar_id_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         ar_burst_q <= ar_burst_d;
         r_addr_q   <= r_addr_d;
         r_beat_q   <= r_beat_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rlast_q    <= rlast_d;
         rid_q      <= rid_d;
      end
   end

   assign bus.AWREADY = awready_q;
   assign bus.WREADY  = wready_q;
   assign bus.BVALID  = bvalid_q;
   assign bus.BID     = bid_q;
   assign bus.BRESP   = bresp_q;
   assign bus.ARREADY = arready_q;
   assign bus.RVALID  = rvalid_q;
   assign bus.RID     = rid_q;
   assign bus.RDATA   = rdata_q;
   assign bus.RRESP   = rresp_q;
   assign bus.RLAST   = rlast_q;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: single/INCR/WRAP/FIXED bursts, strobes, error
// responses, backpressure and mid-burst reset.
module tb_axi_slave_mem;
   localparam int Timeout = 50;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   axi_slave_mem_if #(.WIDTH(32), .SIZE(3)) bus ();

   axi_slave_mem #(.WIDTH(32), .SIZE(3), .MEM_BYTES(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] wdat [16];
   logic [3:0]  wstb [16];
   logic [31:0] rdat [16];
   logic [1:0]  rrsp [16];
   logic        rlst [16];
   logic [3:0]  rid_got, bid;
   logic [1:0]  bresp;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [3:0] wid, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int last_at, input int bhold,
                            output logic [3:0] bid_o, output logic [1:0] bresp_o);
      int cnt;
      bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
      bus.AWBURST = burst; bus.AWVALID = 1'b1;
      cnt = 0;
      while (bus.AWREADY !== 1'b1 && cnt < Timeout) begin @(posedge clk); #1; cnt++; end
      check_eq("aw_wait", 32'(cnt < Timeout), 1);
      @(posedge clk); #1;
      bus.AWVALID = 1'b0;
      check_eq("aw_ready_drop", 32'(bus.AWREADY), 0);
      check_eq("w_ready_rise", 32'(bus.WREADY), 1);
      for (int b = 0; b <= int'(len); b++) begin
         bus.WID = wid; bus.WDATA = {1'b0, wdat[b]}; bus.WSTRB = wstb[b];
         bus.WLAST = (b == last_at); bus.WVALID = 1'b1;
         cnt = 0;
         while (bus.WREADY !== 1'b1 && cnt < Timeout) begin @(posedge clk); #1; cnt++; end
         if (cnt >= Timeout) check_eq("w_wait", 32'(bus.WREADY), 1);
         @(posedge clk); #1;
      end
      bus.WVALID = 1'b0; bus.WLAST = 1'b0;
      check_eq("b_valid_rise", 32'(bus.BVALID), 1);
      check_eq("w_ready_drop", 32'(bus.WREADY), 0);
      bid_o = bus.BID; bresp_o = bus.BRESP;
      for (int k = 0; k < bhold; k++) begin
         @(posedge clk); #1;
         check_eq("b_hold_valid", 32'(bus.BVALID), 1);
         check_eq("b_hold_id", 32'(bus.BID), 32'(bid_o));
      end
      bus.BREADY = 1'b1;
      @(posedge clk); #1;
      bus.BREADY = 1'b0;
      check_eq("b_valid_drop", 32'(bus.BVALID), 0);
      check_eq("aw_ready_back", 32'(bus.AWREADY), 1);
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall);
      int cnt;
      logic [31:0] d0;
      bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size;
      bus.ARBURST = burst; bus.ARVALID = 1'b1;
      cnt = 0;
      while (bus.ARREADY !== 1'b1 && cnt < Timeout) begin @(posedge clk); #1; cnt++; end
      check_eq("ar_wait", 32'(cnt < Timeout), 1);
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
      check_eq("r_valid_rise", 32'(bus.RVALID), 1);
      check_eq("ar_ready_drop", 32'(bus.ARREADY), 0);
      rid_got = bus.RID;
      d0 = bus.RDATA;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         check_eq("r_stall_data", bus.RDATA, d0);
         check_eq("r_stall_valid", 32'(bus.RVALID), 1);
      end
      bus.RREADY = 1'b1;
      for (int b = 0; b <= int'(len); b++) begin
         cnt = 0;
         while (bus.RVALID !== 1'b1 && cnt < Timeout) begin @(posedge clk); #1; cnt++; end
         if (cnt >= Timeout) check_eq("r_wait", 32'(bus.RVALID), 1);
         rdat[b] = bus.RDATA; rrsp[b] = bus.RRESP; rlst[b] = bus.RLAST;
         @(posedge clk); #1;
      end
      bus.RREADY = 1'b0;
      check_eq("r_valid_drop", 32'(bus.RVALID), 0);
      check_eq("ar_ready_back", 32'(bus.ARREADY), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.AWVALID = 0; bus.AWID = 0; bus.AWADDR = 0; bus.AWLEN = 0; bus.AWSIZE = 0;
      bus.AWBURST = 0; bus.WVALID = 0; bus.WLAST = 0; bus.WID = 0; bus.WSTRB = 0;
      bus.WDATA = 0; bus.BREADY = 0; bus.ARVALID = 0; bus.ARID = 0; bus.ARADDR = 0;
      bus.ARLEN = 0; bus.ARSIZE = 0; bus.ARBURST = 0; bus.RREADY = 0;

      // Reset state, then readiness on the first edge after release
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_awready", 32'(bus.AWREADY), 0);
      check_eq("rst_arready", 32'(bus.ARREADY), 0);
      check_eq("rst_bvalid", 32'(bus.BVALID), 0);
      check_eq("rst_rvalid", 32'(bus.RVALID), 0);
      reset = 1'b1;
      @(posedge clk); #1;
      check_eq("rel_awready", 32'(bus.AWREADY), 1);
      check_eq("rel_arready", 32'(bus.ARREADY), 1);

      // T1 single write
      wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
      axi_write(4'd3, 4'd3, 32'h10, 4'd0, 3'd2, 2'b01, 0, 0, bid, bresp);
      check_eq("t1_bid", 32'(bid), 3);
      check_eq("t1_bresp", 32'(bresp), 0);

      // T2 read-back and 4-beat INCR
      axi_read(4'd5, 32'h10, 4'd0, 3'd2, 2'b01, 0);
      check_eq("t2_rdata", rdat[0], 32'hDEADBEEF);
      check_eq("t2_rid", 32'(rid_got), 5);
      check_eq("t2_rlast", 32'(rlst[0]), 1);
      check_eq("t2_rresp", 32'(rrsp[0]), 0);
      for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
      axi_write(4'd1, 4'd1, 32'h20, 4'd3, 3'd2, 2'b01, 3, 0, bid, bresp);
      check_eq("t2_incr_bresp", 32'(bresp), 0);
      axi_read(4'd2, 32'h20, 4'd3, 3'd2, 2'b01, 0);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("t2_incr_data%0d", i), rdat[i], 32'(i + 1));
         check_eq($sformatf("t2_incr_last%0d", i), 32'(rlst[i]), 32'(i == 3));
      end

      // T3 WRAP at 0x38: A->0x38, B->0x3C, C->0x30, D->0x34
      wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC; wdat[3] = 32'hD;
      axi_write(4'd4, 4'd4, 32'h38, 4'd3, 3'd2, 2'b10, 3, 0, bid, bresp);
      check_eq("t3_bresp", 32'(bresp), 0);
      axi_read(4'd4, 32'h30, 4'd3, 3'd2, 2'b01, 0);
      check_eq("t3_w30", rdat[0], 32'hC);
      check_eq("t3_w34", rdat[1], 32'hD);
      check_eq("t3_w38", rdat[2], 32'hA);
      check_eq("t3_w3c", rdat[3], 32'hB);
      axi_read(4'd4, 32'h38, 4'd3, 3'd2, 2'b10, 0);
      check_eq("t3_wrap_rd0", rdat[0], 32'hA);
      check_eq("t3_wrap_rd2", rdat[2], 32'hC);
      check_eq("t3_wrap_rd3", rdat[3], 32'hD);

      // T4 byte strobes
      wdat[0] = 32'hFFFFFFFF; wstb[0] = 4'hF;
      axi_write(4'd0, 4'd0, 32'h40, 4'd0, 3'd2, 2'b01, 0, 0, bid, bresp);
      wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
      axi_write(4'd0, 4'd0, 32'h40, 4'd0, 3'd2, 2'b01, 0, 0, bid, bresp);
      axi_read(4'd0, 32'h40, 4'd0, 3'd2, 2'b01, 0);
      check_eq("t4_strobe", rdat[0], 32'hFFBBFFDD);

      // FIXED burst: both beats hit 0x70
      wdat[0] = 32'h5; wdat[1] = 32'h6; wstb[0] = 4'hF; wstb[1] = 4'hF;
      axi_write(4'd6, 4'd6, 32'h70, 4'd1, 3'd2, 2'b00, 1, 0, bid, bresp);
      axi_read(4'd6, 32'h70, 4'd1, 3'd2, 2'b00, 0);
      check_eq("fixed_rd0", rdat[0], 32'h6);
      check_eq("fixed_rd1", rdat[1], 32'h6);

      // T5 errors
      wdat[0] = 32'h0BADF00D; wstb[0] = 4'hF;
      axi_write(4'd0, 4'd0, 32'h0, 4'd0, 3'd2, 2'b01, 0, 0, bid, bresp);
      wdat[0] = 32'h12345678;
      axi_write(4'd7, 4'd7, 32'h400, 4'd0, 3'd2, 2'b01, 0, 0, bid, bresp);
      check_eq("t5_oob_bresp", 32'(bresp), 2);
      check_eq("t5_oob_bid", 32'(bid), 7);
      axi_read(4'd0, 32'h0, 4'd0, 3'd2, 2'b01, 0);
      check_eq("t5_ram_kept", rdat[0], 32'h0BADF00D);
      axi_read(4'd1, 32'h400, 4'd0, 3'd2, 2'b01, 0);
      check_eq("t5_oob_rdata", rdat[0], 0);
      check_eq("t5_oob_rresp", 32'(rrsp[0]), 2);
      wdat[0] = 32'h11; wdat[1] = 32'h22;
      axi_write(4'd2, 4'd2, 32'h50, 4'd1, 3'd2, 2'b01, 0, 0, bid, bresp);
      check_eq("t5_wlast_early", 32'(bresp), 2);
      axi_write(4'd7, 4'd8, 32'h54, 4'd0, 3'd2, 2'b01, 0, 0, bid, bresp);
      check_eq("t5_wid_bad", 32'(bresp), 2);

      // T6 backpressure
      axi_read(4'd3, 32'h20, 4'd3, 3'd2, 2'b01, 5);
      check_eq("t6_stall_d0", rdat[0], 32'h1);
      check_eq("t6_stall_d3", rdat[3], 32'h4);
      wdat[0] = 32'h5A5A5A5A;
      axi_write(4'd9, 4'd9, 32'h58, 4'd0, 3'd2, 2'b01, 0, 4, bid, bresp);
      check_eq("t6_bhold_bresp", 32'(bresp), 0);
      check_eq("t6_bhold_bid", 32'(bid), 9);

      // T6 reset in the middle of a 4-beat read
      bus.ARID = 4'd9; bus.ARADDR = 32'h20; bus.ARLEN = 4'd3; bus.ARSIZE = 3'd2;
      bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
      @(posedge clk); #1;
      bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
      @(posedge clk); #1;
      check_eq("t6_mid_rvalid", 32'(bus.RVALID), 1);
      check_eq("t6_mid_rdata", bus.RDATA, 32'h2);
      #2 reset = 1'b0;
      #1;
      check_eq("t6_rst_rvalid", 32'(bus.RVALID), 0);
      check_eq("t6_rst_rdata", bus.RDATA, 0);
      check_eq("t6_rst_arready", 32'(bus.ARREADY), 0);
      bus.RREADY = 1'b0;
      #3 reset = 1'b1;
      @(posedge clk); #1;
      check_eq("t6_post_arready", 32'(bus.ARREADY), 1);
      check_eq("t6_post_rvalid", 32'(bus.RVALID), 0);
      axi_read(4'd1, 32'h24, 4'd0, 3'd2, 2'b01, 0);
      check_eq("t6_ram_after_rst", rdat[0], 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
